// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- RV32I instruction fetch stage
//
// Owns the PC, issues word fetches to instruction memory over a req/gnt/rvalid
// interface, buffers returned words in an in-order queue and presents the head
// instruction, its opcode and its PC to decode with a valid/ready handshake.
// A REDIRECT (taken branch / jump) flushes the queue and discards every
// response still outstanding at that moment.
//
// Parameters
//   RESET_PC  first PC fetched after reset (word aligned)
//   QDEPTH    queue entries (power of 2, >= 2); also the maximum number of
//             words that may be queued plus in flight
//
// Ports
//   CLK, RST                       clock, synchronous active-high reset
//   IMEM_REQ / IMEM_ADDR (out)     fetch request and its word-aligned address
//   IMEM_GNT (in)                  memory accepts the request this cycle
//   IMEM_RVALID / IMEM_RDATA (in)  in-order read response
//   REDIRECT / REDIRECT_PC (in)    branch/jump target from downstream
//   INSTR_VALID (out) / INSTR_READY (in)  decode handshake on the queue head
//   INSTR, OP, INSTR_PC, INSTR_PCPLUS4 (out)  head instruction (NOP when idle)
//
// Optional feature (macro FETCH_ALIGN_CHECK_EN)
//   Defined: a redirect target with non-zero bits [1:0] sets the sticky
//   output FETCH_MISALIGN and blocks further fetching until reset.
//   Undefined: the port is absent and target bits [1:0] are forced to 00.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR,
  output logic [6:0]  OP,
  output logic [31:0] INSTR_PC,
  output logic [31:0] INSTR_PCPLUS4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        FETCH_MISALIGN
`endif
);

  localparam int          PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW  = $clog2(QDEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Control state
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  // Queue storage (data only, never reset; gated by occupancy on the outputs)
  logic [31:0] qdata_q [QDEPTH];
  logic [31:0] qpc_q   [QDEPTH];

  logic          pop_w;
  logic          push_w;
  logic          grant_w;
  logic          fetch_blocked_w;
  logic [CW:0]   used_w;
  logic [31:0]   redirect_pc_w;
  logic [31:0]   resp_pc_w;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      misalign_q <= 1'b0;
    end else if (REDIRECT && (REDIRECT_PC[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign fetch_blocked_w = misalign_q;
  assign FETCH_MISALIGN  = misalign_q;
`else
  // Target bits [1:0] are deliberately ignored in this build.
  logic unused_pc_lo_w;
  assign unused_pc_lo_w  = ^REDIRECT_PC[1:0];
  assign fetch_blocked_w = 1'b0;
`endif

  assign redirect_pc_w = {REDIRECT_PC[31:2], 2'b00};

  // Handshake and credit. A word may only be requested if, after this
  // cycle's pop, queued + outstanding words still leave room for it.
  assign INSTR_VALID = !RST && (occ_q != '0);
  assign pop_w       = INSTR_VALID && INSTR_READY;
  assign used_w      = (CW+1)'(occ_q) + (CW+1)'(inflight_q) - (CW+1)'(pop_w);
  assign IMEM_REQ    = !RST && !REDIRECT && !fetch_blocked_w
                       && (used_w < (CW+1)'(QDEPTH));
  assign IMEM_ADDR   = RST ? RESET_PC : pc_q;
  assign grant_w     = IMEM_REQ && IMEM_GNT;

  // A response is kept only when nothing is left to discard and no redirect
  // is flushing this cycle.
  assign push_w = IMEM_RVALID && !REDIRECT && (drop_q == '0);

  // Responses return in order, so the kept ones still outstanding are the
  // last (inflight - drop) granted addresses, ending just below pc_q.
  assign resp_pc_w = pc_q - (32'(inflight_q - drop_q) << 2);

  always_comb begin
    pc_d       = pc_q;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = inflight_q + CW'(grant_w) - CW'(IMEM_RVALID);
    drop_d     = drop_q;

    if (REDIRECT) begin
      // No grant can happen now, so everything still outstanding after this
      // cycle's response is wrong-path and must be discarded.
      pc_d     = redirect_pc_w;
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = inflight_d;
    end else begin
      if (grant_w) begin
        pc_d = pc_q + 32'd4;
      end
      if (IMEM_RVALID && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push_w) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_w) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + CW'(push_w) - CW'(pop_w);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      occ_q      <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_w) begin
      qdata_q[wr_ptr_q] <= IMEM_RDATA;
      qpc_q[wr_ptr_q]   <= resp_pc_w;
    end
  end

  // Credit accounting must make a write into a full queue impossible.
  always_ff @(posedge CLK) begin
    if (!RST && push_w && !pop_w) begin
      assert (occ_q < CW'(QDEPTH));
    end
  end

  assign INSTR         = INSTR_VALID ? qdata_q[rd_ptr_q] : NOP;
  assign OP            = INSTR[6:0];
  assign INSTR_PC      = INSTR_VALID ? qpc_q[rd_ptr_q] : 32'h0;
  assign INSTR_PCPLUS4 = INSTR_PC + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- directed bench for fetch_unit.
// The memory model records every grant and returns the word one cycle later
// (or holds responses while stall is set). Instruction words are a fixed
// function of their address so the bench knows what each fetch returns.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b1;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b1;
  logic [31:0] INSTR;
  logic [6:0]  OP;
  logic [31:0] INSTR_PC;
  logic [31:0] INSTR_PCPLUS4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        FETCH_MISALIGN;
`endif

  int checks = 0;
  int errors = 0;
  int grants = 0;
  bit stall  = 1'b0;
  logic [31:0] mq[$];

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .IMEM_REQ      (IMEM_REQ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_GNT      (IMEM_GNT),
    .IMEM_RVALID   (IMEM_RVALID),
    .IMEM_RDATA    (IMEM_RDATA),
    .REDIRECT      (REDIRECT),
    .REDIRECT_PC   (REDIRECT_PC),
    .INSTR_VALID   (INSTR_VALID),
    .INSTR_READY   (INSTR_READY),
    .INSTR         (INSTR),
    .OP            (OP),
    .INSTR_PC      (INSTR_PC),
    .INSTR_PCPLUS4 (INSTR_PCPLUS4)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .FETCH_MISALIGN(FETCH_MISALIGN)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[24:0], a[8:2]} ^ 32'hA500_0000;
  endfunction

  // One clock: sample the request just before the edge, then drive the
  // memory response for the following cycle. Returns at posedge + 1.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    #1;
    g = IMEM_REQ && IMEM_GNT;
    a = IMEM_ADDR;
    @(posedge CLK);
    if (RST) begin
      mq.delete();
    end else if (g) begin
      mq.push_back(a);
      grants++;
    end
    #1;
    if (!RST && !stall && (mq.size() > 0)) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = word(mq.pop_front());
    end else begin
      IMEM_RVALID = 1'b0;
      IMEM_RDATA  = 32'h0;
    end
  endtask

  task automatic do_reset();
    RST         = 1'b1;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'h0;
    INSTR_READY = 1'b1;
    IMEM_GNT    = 1'b1;
    stall       = 1'b0;
    tick();
    tick();
    RST    = 1'b0;
    grants = 0;
  endtask

  task automatic test_reset();
    do_reset();
    RST = 1'b1;
    tick();
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", IMEM_REQ); end
    checks++; if (IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 00000000", IMEM_ADDR); end
    checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", INSTR_VALID); end
    checks++; if (INSTR !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr: got %h expected 00000013", INSTR); end
    checks++; if (OP !== 7'b0010011) begin errors++; $display("FAIL rst_op: got %b expected 0010011", OP); end
    checks++; if (INSTR_PC !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 00000000", INSTR_PC); end
    RST = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] ep;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (IMEM_ADDR !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, IMEM_ADDR, 32'(4 * k)); end
      if (k == 1) begin
        checks++;
        if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b expected 0", INSTR_VALID); end
      end else begin
        ep = 32'(4 * (k - 2));
        checks++;
        if (INSTR_VALID !== 1'b1 || INSTR_PC !== ep || INSTR !== word(ep) || INSTR_PCPLUS4 !== ep + 32'd4) begin
          errors++;
          $display("FAIL stream_head[%0d]: got v=%b pc=%h instr=%h pc4=%h expected v=1 pc=%h instr=%h pc4=%h",
                   k, INSTR_VALID, INSTR_PC, INSTR, INSTR_PCPLUS4, ep, word(ep), ep + 32'd4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ep;
    do_reset();
    INSTR_READY = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k >= 2) begin
        checks++;
        if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h0 || INSTR !== word(32'h0)) begin
          errors++;
          $display("FAIL hold_head[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=%h",
                   k, INSTR_VALID, INSTR_PC, INSTR, word(32'h0));
        end
      end
    end
    checks++; if (grants !== 2) begin errors++; $display("FAIL hold_grants: got %0d expected 2", grants); end
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL hold_req: got %b expected 0", IMEM_REQ); end
    INSTR_READY = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      ep = 32'(4 * j);
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_PC !== ep || INSTR !== word(ep)) begin
        errors++;
        $display("FAIL resume[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 j, INSTR_VALID, INSTR_PC, INSTR, ep, word(ep));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] ew;
    int n;
    do_reset();
    stall = 1'b1;
    tick();
    tick();
    checks++; if (grants !== 2) begin errors++; $display("FAIL rdi_grants: got %0d expected 2", grants); end
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rdi_credit_req: got %b expected 0", IMEM_REQ); end
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h100;
    tick();
    REDIRECT = 1'b0;
    stall    = 1'b0;
    checks++; if (IMEM_ADDR !== 32'h100) begin errors++; $display("FAIL rdi_addr: got %h expected 00000100", IMEM_ADDR); end
    checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL rdi_valid: got %b expected 0", INSTR_VALID); end
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (INSTR_VALID === 1'b1) begin
        n = i;
        break;
      end
    end
    ew = word(32'h100);
    checks++; if (n !== 4) begin errors++; $display("FAIL rdi_latency: got %0d cycles expected 4", n); end
    checks++;
    if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h100 || OP !== ew[6:0] || INSTR !== ew) begin
      errors++;
      $display("FAIL rdi_head: got v=%b pc=%h op=%h instr=%h expected v=1 pc=00000100 op=%h instr=%h",
               INSTR_VALID, INSTR_PC, OP, INSTR, ew[6:0], ew);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    for (int k = 1; k <= 4; k++) tick();
    checks++; if (INSTR_VALID !== 1'b1) begin errors++; $display("FAIL rdv_pre_valid: got %b expected 1", INSTR_VALID); end
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h200;
    #1;
    checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rdv_req_in_redirect: got %b expected 0", IMEM_REQ); end
    tick();
    REDIRECT = 1'b0;
    #1;
    checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL rdv_valid: got %b expected 0", INSTR_VALID); end
    checks++;
    if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h200) begin
      errors++;
      $display("FAIL rdv_refetch: got req=%b addr=%h expected req=1 addr=00000200", IMEM_REQ, IMEM_ADDR);
    end
    tick();
    tick();
    checks++;
    if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h200 || INSTR !== word(32'h200)) begin
      errors++;
      $display("FAIL rdv_head: got v=%b pc=%h instr=%h expected v=1 pc=00000200 instr=%h",
               INSTR_VALID, INSTR_PC, INSTR, word(32'h200));
    end
  endtask

  task automatic test_gnt_wrap();
    do_reset();
    tick();
    tick();
    checks++; if (IMEM_ADDR !== 32'h8) begin errors++; $display("FAIL gnt_pre_addr: got %h expected 00000008", IMEM_ADDR); end
    IMEM_GNT = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h8) begin
        errors++;
        $display("FAIL gnt_hold[%0d]: got req=%b addr=%h expected req=1 addr=00000008", k, IMEM_REQ, IMEM_ADDR);
      end
    end
    IMEM_GNT = 1'b1;
    tick();
    checks++; if (IMEM_ADDR !== 32'hC) begin errors++; $display("FAIL gnt_after_addr: got %h expected 0000000c", IMEM_ADDR); end
    tick();
    checks++;
    if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h8) begin
      errors++;
      $display("FAIL gnt_head: got v=%b pc=%h expected v=1 pc=00000008", INSTR_VALID, INSTR_PC);
    end
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFFC;
    tick();
    REDIRECT = 1'b0;
    #1;
    checks++;
    if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_pre: got req=%b addr=%h expected req=1 addr=fffffffc", IMEM_REQ, IMEM_ADDR);
    end
    tick();
    checks++; if (IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", IMEM_ADDR); end
    tick();
    checks++;
    if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'hFFFF_FFFC || INSTR_PCPLUS4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_head: got v=%b pc=%h pc4=%h expected v=1 pc=fffffffc pc4=00000000",
               INSTR_VALID, INSTR_PC, INSTR_PCPLUS4);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    tick();
    tick();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h102;
    tick();
    REDIRECT = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (FETCH_MISALIGN !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", FETCH_MISALIGN); end
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin
        errors++;
        $display("FAIL mis_block[%0d]: got req=%b v=%b expected req=0 v=0", k, IMEM_REQ, INSTR_VALID);
      end
      tick();
    end
    do_reset();
    checks++; if (FETCH_MISALIGN !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", FETCH_MISALIGN); end
`else
    checks++;
    if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin
      errors++;
      $display("FAIL mis_force: got req=%b addr=%h expected req=1 addr=00000100", IMEM_REQ, IMEM_ADDR);
    end
    tick();
    tick();
    checks++;
    if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h100) begin
      errors++;
      $display("FAIL mis_head: got v=%b pc=%h expected v=1 pc=00000100", INSTR_VALID, INSTR_PC);
    end
`endif
  endtask

  task automatic test_reset_midop();
    logic [31:0] ep;
    do_reset();
    for (int k = 1; k <= 3; k++) tick();
    RST = 1'b1;
    tick();
    checks++;
    if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0 || IMEM_ADDR !== 32'h0) begin
      errors++;
      $display("FAIL midrst_out: got req=%b v=%b addr=%h expected req=0 v=0 addr=00000000", IMEM_REQ, INSTR_VALID, IMEM_ADDR);
    end
    tick();
    RST = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k >= 2) begin
        ep = 32'(4 * (k - 2));
        checks++;
        if (INSTR_VALID !== 1'b1 || INSTR_PC !== ep) begin
          errors++;
          $display("FAIL midrst_restart[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, INSTR_VALID, INSTR_PC, ep);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_gnt_wrap();
    test_misalign();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
